// File: rtl/mem_wait_responder_if.sv
// Read/write handshake between the read controller and the slow-memory responder.
// The wr/wdata write path exists only when MEM_WRITE_EN is defined.
interface mem_wait_responder_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          rd;
    logic [AW-1:0] addr;
`ifdef MEM_WRITE_EN
    logic          wr;
    logic [DW-1:0] wdata;
`endif
    logic          ws;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;

    modport master (
`ifdef MEM_WRITE_EN
        output wr,
        output wdata,
`endif
        output rd,
        output addr,
        input  ws,
        input  rdata,
        input  rvalid,
        input  busy
    );

    modport slave (
`ifdef MEM_WRITE_EN
        input  wr,
        input  wdata,
`endif
        input  rd,
        input  addr,
        output ws,
        output rdata,
        output rvalid,
        output busy
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Slow-memory responder: holds ws for WAIT_CYC cycles per read, then returns data with an rvalid pulse.
// Optional single-cycle write port enabled by defining MEM_WRITE_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for rd (or wr); ws = 0, busy = 0
// ST_WAIT | stalling controller; ws = 1, counter runs down to zero
// ST_DATA | rdata just updated; rvalid = 1 for this one cycle
module mem_wait_responder #(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int WAIT_CYC = 2
) (
    input logic                clk,
    input logic                rst_n,
    mem_wait_responder_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] rdata_q;
    logic          ws_q;
    logic          rvalid_q;
    logic          busy_q;
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            rdata_q  <= '0;
            ws_q     <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DW'(i);
            end
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rd) begin
                        addr_q <= bus.addr;
                        busy_q <= 1'b1;
                        if (WAIT_CYC == 0) begin
                            rdata_q  <= mem_q[bus.addr];
                            rvalid_q <= 1'b1;
                            state_q  <= ST_DATA;
                        end else begin
                            cnt_q   <= WAIT_LOAD;
                            ws_q    <= 1'b1;
                            state_q <= ST_WAIT;
                        end
                    end
`ifdef MEM_WRITE_EN
                    // rd takes priority; a write colliding with a read is dropped
                    else if (bus.wr) begin
                        mem_q[bus.addr] <= bus.wdata;
                    end
`endif
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q  <= mem_q[addr_q];
                        ws_q     <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DATA: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ws_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ws     = ws_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance.
// Write-path steps run only when MEM_WRITE_EN is defined.
module tb_mem_wait_responder;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    mem_wait_responder_if #(.DW(8), .AW(4)) bus  ();
    mem_wait_responder_if #(.DW(8), .AW(4)) bus0 ();

    mem_wait_responder #(.DW(8), .AW(4), .WAIT_CYC(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mem_wait_responder #(.DW(8), .AW(4), .WAIT_CYC(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance past the next rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rd    = 1'b0;
        bus.addr  = '0;
        bus0.rd   = 1'b0;
        bus0.addr = '0;
`ifdef MEM_WRITE_EN
        bus.wr     = 1'b0;
        bus.wdata  = '0;
        bus0.wr    = 1'b0;
        bus0.wdata = '0;
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        check("rst_ws",      32'(bus.ws),     32'd0);
        check("rst_rvalid",  32'(bus.rvalid), 32'd0);
        check("rst_busy",    32'(bus.busy),   32'd0);
        check("rst_rdata",   32'(bus.rdata),  32'h00);
        check("rst0_rdata",  32'(bus0.rdata), 32'h00);
        check("rst0_busy",   32'(bus0.busy),  32'd0);

        // basic read addr 5
        bus.rd = 1'b1; bus.addr = 4'h5;
        step();                                    // edge N
        bus.rd = 1'b0; bus.addr = 4'h0;
        check("rd5_ws_n",      32'(bus.ws),     32'd1);
        check("rd5_busy_n",    32'(bus.busy),   32'd1);
        check("rd5_rvalid_n",  32'(bus.rvalid), 32'd0);
        step();                                    // N+1
        check("rd5_ws_n1",     32'(bus.ws),     32'd1);
        check("rd5_rvalid_n1", 32'(bus.rvalid), 32'd0);
        check("rd5_rdata_n1",  32'(bus.rdata),  32'h00);
        step();                                    // N+2
        check("rd5_ws_n2",     32'(bus.ws),     32'd0);
        check("rd5_rvalid_n2", 32'(bus.rvalid), 32'd1);
        check("rd5_rdata_n2",  32'(bus.rdata),  32'h05);
        check("rd5_busy_n2",   32'(bus.busy),   32'd1);
        step();                                    // N+3
        check("rd5_rvalid_n3", 32'(bus.rvalid), 32'd0);
        check("rd5_busy_n3",   32'(bus.busy),   32'd0);
        check("rd5_rdata_n3",  32'(bus.rdata),  32'h05);

        // busy rejection: rd held, addr switches to 9 during the first read
        bus.rd = 1'b1; bus.addr = 4'h3;
        step();                                    // edge M accepts addr 3
        bus.addr = 4'h9;
        step();                                    // M+1
        check("rej_ws_m1",     32'(bus.ws),     32'd1);
        step();                                    // M+2
        check("rej_rdata1",    32'(bus.rdata),  32'h03);
        check("rej_rvalid1",   32'(bus.rvalid), 32'd1);
        step();                                    // M+3, DATA->IDLE, rd ignored
        check("rej_busy_m3",   32'(bus.busy),   32'd0);
        check("rej_ws_m3",     32'(bus.ws),     32'd0);
        check("rej_rvalid_m3", 32'(bus.rvalid), 32'd0);
        step();                                    // M+4 accepts addr 9
        bus.rd = 1'b0; bus.addr = 4'h1;            // ignored during WAIT
        check("rej_ws_m4",     32'(bus.ws),     32'd1);
        step();                                    // M+5
        check("rej_rvalid_m5", 32'(bus.rvalid), 32'd0);
        step();                                    // M+6
        check("rej_rdata2",    32'(bus.rdata),  32'h09);
        check("rej_rvalid2",   32'(bus.rvalid), 32'd1);
        step();

        // zero-wait instance, addr A
        bus0.rd = 1'b1; bus0.addr = 4'hA;
        step();
        bus0.rd = 1'b0; bus0.addr = 4'h0;
        check("zw_ws",       32'(bus0.ws),     32'd0);
        check("zw_rdata",    32'(bus0.rdata),  32'h0A);
        check("zw_rvalid",   32'(bus0.rvalid), 32'd1);
        check("zw_busy",     32'(bus0.busy),   32'd1);
        step();
        check("zw_rvalid_1", 32'(bus0.rvalid), 32'd0);
        check("zw_busy_1",   32'(bus0.busy),   32'd0);
        check("zw_ws_1",     32'(bus0.ws),     32'd0);

        // reset mid-read during the second WAIT cycle
        bus.rd = 1'b1; bus.addr = 4'h7;
        step();
        bus.rd = 1'b0;
        check("mr_ws_w1", 32'(bus.ws), 32'd1);
        step();
        check("mr_ws_w2", 32'(bus.ws), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_ws_async",     32'(bus.ws),     32'd0);
        check("mr_rvalid_async", 32'(bus.rvalid), 32'd0);
        check("mr_rdata_async",  32'(bus.rdata),  32'h00);
        check("mr_busy_async",   32'(bus.busy),   32'd0);
        step();
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("mr_no_rvalid", 32'(bus.rvalid), 32'd0);
        end
        check("mr_rdata_after", 32'(bus.rdata), 32'h00);

`ifdef MEM_WRITE_EN
        // single-cycle write to addr 2
        bus.wr = 1'b1; bus.addr = 4'h2; bus.wdata = 8'hC3;
        step();
        bus.wr = 1'b0;
        check("wr_busy", 32'(bus.busy), 32'd0);
        check("wr_ws",   32'(bus.ws),   32'd0);
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        step(); step();
        check("wr_rdata_c3", 32'(bus.rdata), 32'hC3);
        step();

        // rd and wr together: read wins, write dropped
        bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 4'h6; bus.wdata = 8'hFF;
        step();
        bus.rd = 1'b0; bus.wr = 1'b0;
        step(); step();
        check("rw_rdata", 32'(bus.rdata), 32'h06);
        step();
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
        step(); step();
        check("rw_reread", 32'(bus.rdata), 32'h06);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
